// File: rtl/jtkunio_pkg.sv
// Shared constants and types for the Kunio scroll ROM slot.
package jtkunio_pkg;

  localparam int SCR_AW   = 17;
  localparam int SDRAM_AW = 22;

  localparam logic [SDRAM_AW-1:0] SCR_BASE = 22'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEAT0,
    ST_BEAT1
  } romslot_st_e;

endpackage

// File: rtl/jtkunio_romslot_cache2.sv
// Two-entry line cache: tag/valid/data storage, hit compare and LRU victim pointer.
module jtkunio_romslot_cache2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lk_en,
  input  logic [15:0] lk_tag,
  input  logic        fill_en,
  input  logic [15:0] fill_tag,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        victim
);

  logic [1:0][15:0] tag_q, tag_d;
  logic [1:0][31:0] dat_q, dat_d;
  logic [1:0]       vld_q, vld_d;
  logic             lru_q, lru_d;
  logic [1:0]       hit_vec;
  logic             hit_idx;

  // Lookup against both entries
  always_comb begin
    hit_vec[0] = lk_en && vld_q[0] && (tag_q[0] == lk_tag);
    hit_vec[1] = lk_en && vld_q[1] && (tag_q[1] == lk_tag);
    hit        = |hit_vec;
    hit_idx    = hit_vec[1];
    hit_data   = dat_q[hit_idx];
    victim     = lru_q;
  end

  // Storage update; a fill in the same cycle as a hit takes priority for LRU
  always_comb begin
    tag_d = tag_q;
    dat_d = dat_q;
    vld_d = vld_q;
    lru_d = lru_q;
    if (hit) lru_d = ~hit_idx;
    if (fill_en) begin
      tag_d[lru_q] = fill_tag;
      dat_d[lru_q] = fill_data;
      vld_d[lru_q] = 1'b1;
      lru_d        = ~lru_q;
    end
  end

  // Cache state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      dat_q <= '0;
      vld_q <= '0;
      lru_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
      lru_q <= lru_d;
    end
  end

endmodule

// File: rtl/jtkunio_scr_romslot.sv
// Scroll-layer ROM responder: serves hits from a 2-entry cache, turns misses
// into two-beat SDRAM reads and forwards the fill data when still wanted.
module jtkunio_scr_romslot
  import jtkunio_pkg::*;
#(
  parameter logic [21:0] BASE = SCR_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rom_cs,
  input  logic [16:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_din,
  input  logic        sdram_rdy
);

  romslot_st_e st_q, st_d;
  logic [15:0] pend_tag_q, pend_tag_d;
  logic [15:0] low_q, low_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;
  logic        ok_q, ok_d;
  logic [31:0] data_q, data_d;

  logic [15:0] lk_tag;
  logic        hit;
  logic [31:0] hit_data;
  logic        victim;
  logic        fill_en;
  logic [31:0] fill_data;

  assign lk_tag    = rom_addr[16:1];
  assign fill_en   = (st_q == ST_BEAT1) && sdram_dst && sdram_rdy;
  assign fill_data = {sdram_din, low_q};

  jtkunio_romslot_cache2 u_cache (
    .clk      (clk),
    .rst_n    (rst_n),
    .lk_en    (rom_cs),
    .lk_tag   (lk_tag),
    .fill_en  (fill_en),
    .fill_tag (pend_tag_q),
    .fill_data(fill_data),
    .hit      (hit),
    .hit_data (hit_data),
    .victim   (victim)
  );

  // Fetch FSM, SDRAM handshake and rom_data/rom_ok selection
  always_comb begin
    st_d       = st_q;
    pend_tag_d = pend_tag_q;
    low_d      = low_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ok_d       = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (rom_cs && !hit) begin
          pend_tag_d = lk_tag;
          addr_d     = BASE + {5'd0, rom_addr};
          req_d      = 1'b1;
          st_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          st_d  = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (sdram_dst) begin
          low_d = sdram_din;
          st_d  = ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (fill_en) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    // The fill bypass wins: the cache entry only becomes visible next cycle
    if (fill_en && rom_cs && (lk_tag == pend_tag_q)) begin
      ok_d   = 1'b1;
      data_d = fill_data;
    end else if (hit) begin
      ok_d   = 1'b1;
      data_d = hit_data;
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      pend_tag_q <= '0;
      low_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      ok_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      st_q       <= st_d;
      pend_tag_q <= pend_tag_d;
      low_q      <= low_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ok_q       <= ok_d;
      data_q     <= data_d;
    end
  end

  assign rom_data   = data_q;
  assign rom_ok     = ok_q;
  assign sdram_addr = addr_q;
  assign sdram_req  = req_q;

endmodule

// File: tb/tb_jtkunio_scr_romslot.sv
// Scoreboard bench for jtkunio_scr_romslot: expected rom_data events and
// expected SDRAM request addresses are queued by the stimulus and consumed
// by independent monitors.
module tb_jtkunio_scr_romslot;

  localparam logic [21:0] TB_BASE = 22'h100000;

  localparam logic [16:0] A_ADR = 17'h00120;
  localparam logic [16:0] B_ADR = 17'h00122;
  localparam logic [16:0] C_ADR = 17'h00200;
  localparam logic [16:0] D_ADR = 17'h00300;
  localparam logic [16:0] E_ADR = 17'h00400;

  localparam logic [31:0] A_DAT = 32'hDEADBEEF;
  localparam logic [31:0] B_DAT = 32'h12345678;
  localparam logic [31:0] C_DAT = 32'hCAFEF00D;
  localparam logic [31:0] D_DAT = 32'hA5A55A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_cs = 1'b0;
  logic [16:0] rom_addr = '0;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_din = '0;
  logic        sdram_rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        dq[$];
  logic [21:0] rq[$];

  jtkunio_scr_romslot #(.BASE(TB_BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .sdram_addr(sdram_addr),
    .sdram_req (sdram_req),
    .sdram_ack (sdram_ack),
    .sdram_dst (sdram_dst),
    .sdram_din (sdram_din),
    .sdram_rdy (sdram_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Data monitor: an event is rom_ok rising or new data while rom_ok is high
  logic        prev_ok = 1'b0;
  logic [31:0] prev_data = '0;
  exp_t        de;
  always @(negedge clk) begin
    if (rom_ok === 1'b1 && (!prev_ok || rom_data !== prev_data)) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL data_event unexpected: rom_data=%h at cyc %0d, required no event", rom_data, cyc);
      end else begin
        de = dq.pop_front();
        if (rom_data !== de.data || cyc != de.cyc) begin
          failures++;
          $display("FAIL data_event: got %h at cyc %0d, required %h at cyc %0d", rom_data, cyc, de.data, de.cyc);
        end
      end
    end
    prev_ok   = rom_ok;
    prev_data = rom_data;
  end

  // Request monitor: every sdram_req rise must match the next expected address
  logic        prev_req = 1'b0;
  logic [21:0] re;
  always @(negedge clk) begin
    if (sdram_req === 1'b1 && !prev_req) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL sdram_req unexpected: sdram_addr=%h at cyc %0d, required no request", sdram_addr, cyc);
      end else begin
        re = rq.pop_front();
        if (sdram_addr !== re) begin
          failures++;
          $display("FAIL sdram_addr: got %h, required %h", sdram_addr, re);
        end
      end
    end
    prev_req = sdram_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive a new address and queue what it should produce
  task automatic set_addr(input logic [16:0] a, input bit miss, input logic [31:0] hd);
    rom_addr = a;
    if (miss) rq.push_back(TB_BASE + {5'd0, a});
    else dq.push_back('{data: hd, cyc: cyc + 1});
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (sdram_req === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_req: sdram_req=0 after 10 cycles, required 1");
    end
  endtask

  task automatic ack_phase();
    repeat (2) tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] lo, input logic [15:0] hi, input bit bypass,
                       input bit sw, input logic [16:0] sw_a, input logic [31:0] sw_d);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    ack_phase();
    sdram_dst = 1'b1;
    sdram_din = lo;
    if (sw) set_addr(sw_a, 1'b0, sw_d);
    tick();
    sdram_din = hi;
    sdram_rdy = 1'b1;
    if (bypass) dq.push_back('{data: {hi, lo}, cyc: cyc + 1});
    tick();
    sdram_dst = 1'b0;
    sdram_rdy = 1'b0;
    sdram_din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bit ok;
    // Reset state
    repeat (3) tick();
    check1("reset_rom_ok", {31'd0, rom_ok}, 32'd0);
    check1("reset_sdram_req", {31'd0, sdram_req}, 32'd0);
    check1("reset_rom_data", rom_data, 32'd0);
    check1("reset_sdram_addr", {10'd0, sdram_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Stray ack/strobe in IDLE with rom_cs low
    sdram_ack = 1'b1;
    sdram_dst = 1'b1;
    sdram_din = 16'hFFFF;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    sdram_din = '0;
    tick();
    check1("stray_no_req", {31'd0, sdram_req}, 32'd0);

    // Cold miss A with bypass on the rdy edge
    rom_cs = 1'b1;
    set_addr(A_ADR, 1'b1, '0);
    fetch(16'hBEEF, 16'hDEAD, 1'b1, 1'b0, '0, '0);
    repeat (3) tick();

    // Fill B
    set_addr(B_ADR, 1'b1, '0);
    fetch(16'h5678, 16'h1234, 1'b1, 1'b0, '0, '0);
    repeat (3) tick();

    // Alternating hits, no SDRAM traffic
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) set_addr(A_ADR, 1'b0, A_DAT);
      else set_addr(B_ADR, 1'b0, B_DAT);
      repeat (8) tick();
    end

    // LRU: hit A, then C evicts B
    set_addr(A_ADR, 1'b0, A_DAT);
    repeat (4) tick();
    set_addr(C_ADR, 1'b1, '0);
    fetch(16'hF00D, 16'hCAFE, 1'b1, 1'b0, '0, '0);
    repeat (2) tick();
    set_addr(A_ADR, 1'b0, A_DAT);
    repeat (3) tick();
    set_addr(B_ADR, 1'b1, '0);
    fetch(16'h5678, 16'h1234, 1'b1, 1'b0, '0, '0);
    repeat (2) tick();
    set_addr(A_ADR, 1'b0, A_DAT);
    repeat (3) tick();

    // Address change mid-fetch: D misses, switch to cached B, D fills anyway
    set_addr(D_ADR, 1'b1, '0);
    fetch(16'h5A5A, 16'hA5A5, 1'b0, 1'b1, B_ADR, B_DAT);
    repeat (3) tick();
    set_addr(D_ADR, 1'b0, D_DAT);
    repeat (3) tick();
    set_addr(B_ADR, 1'b0, B_DAT);
    repeat (3) tick();

    // rom_cs low clears rom_ok and blocks new requests
    rom_cs = 1'b0;
    repeat (2) tick();
    check1("cs_low_rom_ok", {31'd0, rom_ok}, 32'd0);
    rom_addr = E_ADR;
    repeat (3) tick();
    check1("cs_low_no_req", {31'd0, sdram_req}, 32'd0);
    rom_addr = B_ADR;
    rom_cs = 1'b1;
    dq.push_back('{data: B_DAT, cyc: cyc + 1});
    repeat (3) tick();

    // Reset during BEAT1: no fill, same address misses again after release
    set_addr(E_ADR, 1'b1, '0);
    wait_req(ok);
    ack_phase();
    sdram_dst = 1'b1;
    sdram_din = 16'h1111;
    tick();
    rst_n = 1'b0;
    sdram_din = 16'h2222;
    sdram_rdy = 1'b1;
    #1;
    check1("midreset_rom_ok", {31'd0, rom_ok}, 32'd0);
    check1("midreset_sdram_req", {31'd0, sdram_req}, 32'd0);
    check1("midreset_rom_data", rom_data, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    sdram_din = 16'h3333;
    rq.push_back(TB_BASE + {5'd0, E_ADR});
    tick();
    sdram_dst = 1'b0;
    sdram_rdy = 1'b0;
    sdram_din = '0;
    fetch(16'h1111, 16'h2222, 1'b1, 1'b0, '0, '0);
    repeat (5) tick();

    checks++;
    if (dq.size() != 0) begin
      failures++;
      $display("FAIL data_queue_drain: got %0d pending, required 0", dq.size());
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL req_queue_drain: got %0d pending, required 0", rq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
